fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the CPU execute sequencer. Reads one- and two-word instructions from RAM over a granted, shared RAM read port. Presents each instruction (opcode word plus optional immediate word) with its PC to the execute stage through a valid/ready handshake. Handles branch redirects and flushes any fetch in flight.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
RAM_LATENCY, 1, cycles from a granted address to valid bus_RAM_DATA_OUT (legal range 1..4).

Ports:
wire_clock  in  1  system clock, all state updates on posedge.
wire_reset_n  in  1  asynchronous active-low reset.
bus_RAM_DATA_OUT  in  16  read data returned by RAM.
bus_FETCH_ADDRESS  out  16  read address driven to the RAM address mux.
wire_fetch_bus_req  out  1  fetch requests the RAM port; read-only, so RW is never driven here.
wire_fetch_bus_gnt  in  1  arbiter grant; the execute stage has priority.
bus_IR  out  16  instruction word.
bus_IMM  out  16  second word for two-word opcodes; 16'h0000 otherwise.
bus_PC  out  16  address of bus_IR.
wire_instr_valid  out  1  bus_IR/bus_IMM/bus_PC hold a complete instruction.
wire_instr_ready  in  1  execute stage accepts the instruction this cycle.
wire_branch_taken  in  1  one-cycle pulse to redirect the fetch.
bus_branch_target  in  16  new fetch PC, sampled when wire_branch_taken=1.

Behaviour:
- Reset (async, wire_reset_n=0): fetch PC=RESET_PC; bus_IR, bus_IMM, bus_PC=0; wire_instr_valid=0; wire_fetch_bus_req=0; bus_FETCH_ADDRESS=RESET_PC; state=IDLE.
- States: IDLE, REQ_W0, WAIT_W0, REQ_W1, WAIT_W1, HOLD.
- IDLE -> REQ_W0 on the first cycle after reset is released.
- REQ_W0: req=1, address=PC. When gnt=1, start the latency counter and go to WAIT_W0.
- WAIT_W0: req and address are held. After RAM_LATENCY cycles, capture bus_RAM_DATA_OUT into bus_IR, set bus_PC=PC, and set PC=PC+1.
  - If IR[15:10] is in {110000 LOAD, 110001 STORE, 111000 LOADN, 000010 JMP-class, 000011 CALL-class}, go to REQ_W1.
  - Otherwise set bus_IMM=0 and valid=1, and go to HOLD.
- REQ_W1 / WAIT_W1: same as the W0 states, but capture into bus_IMM, set PC=PC+1, set valid=1, then go to HOLD.
- HOLD: outputs stay stable while valid=1 and ready=0. On ready=1: valid=0 the next cycle and go to REQ_W0. Fetch never prefetches past an unaccepted instruction.
- Grant loss: if gnt drops during WAIT_*, abandon the read and return to the matching REQ_* state with the same address. A later data beat is never captured for the abandoned read.
- Latency: a one-word instruction with continuous grant gives valid=1 at RAM_LATENCY+1 cycles after entering REQ_W0. A two-word instruction gives valid=1 at 2*(RAM_LATENCY+1) cycles.
- Branch: when wire_branch_taken=1 in any state, the next cycle has PC=bus_branch_target, valid=0, state=REQ_W0. Any in-flight or held instruction is dropped.
  - Branch and ready in the same cycle: branch wins.
  - Branch during reset: ignored.
- PC arithmetic is 16-bit unsigned and wraps from 16'hFFFF to 16'h0000. A two-word instruction at 16'hFFFF fetches its immediate from 16'h0000.
- Reset asserted mid-read: all state clears immediately and req drops asynchronously.

Optional Feature:
FETCH_DEBUG_EN
- Defined: adds output data_debug[15:0] = {state code[3:0], 4'h0, accepted-instruction count[7:0]}. The count increments on each valid&ready, wraps at 8'hFF, and resets to 0.
- Undefined: the port and counter are absent; functional behaviour is identical.

Test Plan:
- Reset release, RAM[0]=16'h0400 (one-word), RAM_LATENCY=1, gnt=1, ready=1 -> valid on cycle 2 with IR=16'h0400, IMM=0, PC=0; next fetch address is 1.
- RAM[0]=16'hE000 (LOADN), RAM[1]=16'h1234 -> a single valid with IR=16'hE000, IMM=16'h1234, PC=0; next fetch address is 2.
- ready=0 for 5 cycles after valid -> IR/IMM/PC stable, req=0, no RAM reads; ready=1 -> fetch resumes at the next PC.
- Drop gnt for 3 cycles in WAIT_W1 of a STORE -> the same address is re-requested, IMM is taken from the re-issued read, and exactly one valid occurs.
- Branch pulse to 16'h0100 while in WAIT_W0, and again in HOLD together with ready=1 -> the next address is 16'h0100 and the dropped instruction never appears.
- PC=16'hFFFF holding a LOAD opcode -> IMM is read from 16'h0000 and the next PC is 16'h0001; with FETCH_DEBUG_EN, the count increments once per accepted instruction.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: shared RAM read port plus the instruction valid/ready
// handshake and branch redirect toward the execute stage.
interface fetch_unit_if;
  logic [15:0] bus_RAM_DATA_OUT;
  logic [15:0] bus_FETCH_ADDRESS;
  logic        wire_fetch_bus_req;
  logic        wire_fetch_bus_gnt;
  logic [15:0] bus_IR;
  logic [15:0] bus_IMM;
  logic [15:0] bus_PC;
  logic        wire_instr_valid;
  logic        wire_instr_ready;
  logic        wire_branch_taken;
  logic [15:0] bus_branch_target;

  modport master (
    input  bus_RAM_DATA_OUT, wire_fetch_bus_gnt, wire_instr_ready,
           wire_branch_taken, bus_branch_target,
    output bus_FETCH_ADDRESS, wire_fetch_bus_req, bus_IR, bus_IMM, bus_PC,
           wire_instr_valid
  );

  modport slave (
    output bus_RAM_DATA_OUT, wire_fetch_bus_gnt, wire_instr_ready,
           wire_branch_taken, bus_branch_target,
    input  bus_FETCH_ADDRESS, wire_fetch_bus_req, bus_IR, bus_IMM, bus_PC,
           wire_instr_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: reads one/two-word instructions over a granted RAM port and
// offers them to execute via valid/ready. Optional macro FETCH_DEBUG_EN adds data_debug.
module fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          RAM_LATENCY = 1
) (
  input  logic         wire_clock,
  input  logic         wire_reset_n,
  fetch_unit_if.master fbus
`ifdef FETCH_DEBUG_EN
  ,
  output logic [15:0]  data_debug
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_W0  = 3'd1,
    WAIT_W0 = 3'd2,
    REQ_W1  = 3'd3,
    WAIT_W1 = 3'd4,
    HOLD    = 3'd5
  } state_t;

  localparam logic [1:0] LAT_LOAD = 2'(RAM_LATENCY - 1);

  state_t      state, state_nxt;
  logic [15:0] fetch_pc;
  logic [1:0]  lat_cnt;
  logic        gnt, branch, lat_done, two_word, launch, cap_w0, cap_w1;

  function automatic logic opcode_is_two_word(input logic [5:0] op);
    return op inside {6'b110000, 6'b110001, 6'b111000, 6'b000010, 6'b000011};
  endfunction

  assign gnt      = fbus.wire_fetch_bus_gnt;
  assign branch   = fbus.wire_branch_taken;
  assign lat_done = (lat_cnt == 2'd0);
  assign two_word = opcode_is_two_word(fbus.bus_RAM_DATA_OUT[15:10]);
  assign launch   = ((state == REQ_W0) || (state == REQ_W1)) && gnt;
  // A beat is only taken if the grant held through the whole wait window.
  assign cap_w0   = !branch && (state == WAIT_W0) && gnt && lat_done;
  assign cap_w1   = !branch && (state == WAIT_W1) && gnt && lat_done;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wire_clock or negedge wire_reset_n) begin
    if (!wire_reset_n) state <= IDLE;
    else               state <= state_nxt;
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    if (branch) begin
      state_nxt = REQ_W0;
    end else begin
      case (state)
        IDLE:    state_nxt = REQ_W0;
        REQ_W0:  if (gnt) state_nxt = WAIT_W0;
        WAIT_W0: begin
          if (!gnt)          state_nxt = REQ_W0;
          else if (lat_done) state_nxt = two_word ? REQ_W1 : HOLD;
        end
        REQ_W1:  if (gnt) state_nxt = WAIT_W1;
        WAIT_W1: begin
          if (!gnt)          state_nxt = REQ_W1;
          else if (lat_done) state_nxt = HOLD;
        end
        HOLD:    if (fbus.wire_instr_ready) state_nxt = REQ_W0;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    fbus.wire_fetch_bus_req = 1'b0;
    fbus.wire_instr_valid   = 1'b0;
    case (state)
      REQ_W0, WAIT_W0, REQ_W1, WAIT_W1: fbus.wire_fetch_bus_req = 1'b1;
      HOLD:                             fbus.wire_instr_valid   = 1'b1;
      default: ;
    endcase
  end

  assign fbus.bus_FETCH_ADDRESS = fetch_pc;

  always_ff @(posedge wire_clock or negedge wire_reset_n) begin
    if (!wire_reset_n) begin
      fetch_pc     <= RESET_PC;
      lat_cnt      <= 2'd0;
      fbus.bus_IR  <= 16'h0000;
      fbus.bus_IMM <= 16'h0000;
      fbus.bus_PC  <= 16'h0000;
    end else if (branch) begin
      fetch_pc <= fbus.bus_branch_target;
    end else begin
      if (launch)                                                  lat_cnt <= LAT_LOAD;
      else if ((state == WAIT_W0 || state == WAIT_W1) && !lat_done) lat_cnt <= lat_cnt - 2'd1;

      if (cap_w0) begin
        fbus.bus_IR <= fbus.bus_RAM_DATA_OUT;
        fbus.bus_PC <= fetch_pc;
        fetch_pc    <= fetch_pc + 16'd1;
        if (!two_word) fbus.bus_IMM <= 16'h0000;
      end
      if (cap_w1) begin
        fbus.bus_IMM <= fbus.bus_RAM_DATA_OUT;
        fetch_pc     <= fetch_pc + 16'd1;
      end
    end
  end

`ifdef FETCH_DEBUG_EN
  logic [7:0] accept_cnt;

  always_ff @(posedge wire_clock or negedge wire_reset_n) begin
    if (!wire_reset_n)                                accept_cnt <= 8'd0;
    else if (state == HOLD && fbus.wire_instr_ready) accept_cnt <= accept_cnt + 8'd1;
  end

  assign data_debug = {1'b0, state, 4'h0, accept_cnt};
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal expectations,
// then randomized grant/ready/branch traffic checked against an instruction-stream model.
module tb_fetch_unit;
  localparam int          LAT    = 1;
  localparam logic [15:0] RST_PC = 16'h0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if fbus();
`ifdef FETCH_DEBUG_EN
  logic [15:0] data_debug;
`endif

  fetch_unit #(.RESET_PC(RST_PC), .RAM_LATENCY(LAT)) dut (
    .wire_clock  (clk),
    .wire_reset_n(rst_n),
    .fbus        (fbus)
`ifdef FETCH_DEBUG_EN
    ,
    .data_debug  (data_debug)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic is2(input logic [15:0] w);
    return w[15:10] inside {6'h30, 6'h31, 6'h38, 6'h02, 6'h03};
  endfunction

  // RAM: data appears LAT cycles after a granted address; otherwise junk.
  logic [15:0] mem [65536];
  logic        pipe_v [LAT] = '{default: 1'b0};
  logic [15:0] pipe_a [LAT];
  logic [15:0] junk = 16'h0;

  always @(posedge clk) begin
    pipe_v[0] <= fbus.wire_fetch_bus_req && fbus.wire_fetch_bus_gnt;
    pipe_a[0] <= fbus.bus_FETCH_ADDRESS;
    for (int i = 1; i < LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_a[i] <= pipe_a[i-1];
    end
    junk <= 16'($urandom);
  end

  assign fbus.bus_RAM_DATA_OUT = pipe_v[LAT-1] ? mem[pipe_a[LAT-1]] : junk;

  // Instruction-stream model: the next instruction offered is always the one at m_pc.
  logic [15:0] m_pc       = RST_PC;
  logic        prev_valid = 1'b0;
  int          accepted   = 0;
  int          handshakes = 0;

  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_pc       = RST_PC;
      prev_valid = 1'b0;
      handshakes = 0;
    end else begin
      logic [15:0] nxt, exp_addr;
      if (prev_valid && fbus.wire_instr_ready) handshakes++;
      if (fbus.wire_branch_taken) begin
        m_pc = fbus.bus_branch_target;
      end else if (prev_valid && fbus.wire_instr_ready) begin
        m_pc = m_pc + (is2(mem[m_pc]) ? 16'd2 : 16'd1);
        accepted++;
      end
      nxt = m_pc + 16'd1;
      if (fbus.wire_instr_valid) begin
        check("model_ir",  fbus.bus_IR,  mem[m_pc]);
        check("model_pc",  fbus.bus_PC,  m_pc);
        check("model_imm", fbus.bus_IMM, is2(mem[m_pc]) ? mem[nxt] : 16'h0000);
        check("model_no_prefetch", fbus.wire_fetch_bus_req, 1'b0);
      end
      if (fbus.wire_fetch_bus_req) begin
        exp_addr = (fbus.bus_FETCH_ADDRESS == nxt && is2(mem[m_pc])) ? nxt : m_pc;
        check("model_addr", fbus.bus_FETCH_ADDRESS, exp_addr);
      end
`ifdef FETCH_DEBUG_EN
      check("debug_count", data_debug[7:0], 8'(handshakes));
      check("debug_pad",   data_debug[11:8], 4'h0);
`endif
      prev_valid = fbus.wire_instr_valid;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!fbus.wire_instr_valid && cycles < 50) begin
      tick();
      cycles++;
    end
    if (!fbus.wire_instr_valid) check("valid_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_req_addr(input logic [15:0] a);
    int n = 0;
    while (!(fbus.wire_fetch_bus_req && fbus.bus_FETCH_ADDRESS == a) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("req_addr_timeout", fbus.bus_FETCH_ADDRESS, a);
  endtask

  initial begin
    logic [5:0] ops [5] = '{6'h30, 6'h31, 6'h38, 6'h02, 6'h03};
    int c;

    for (int i = 0; i < 65536; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(0, 9) < 4) w[15:10] = ops[$urandom_range(0, 4)];
      mem[i] = w;
    end
    mem[16'h0000] = 16'h0400;
    mem[16'h0001] = 16'hE000;
    mem[16'h0002] = 16'h1234;
    mem[16'h0003] = 16'hC400;
    mem[16'h0004] = 16'hABCD;
    mem[16'h0005] = 16'h0401;
    mem[16'h0100] = 16'h0800;
    mem[16'h0101] = 16'h5555;
    mem[16'hFFFF] = 16'hC000;

    fbus.wire_fetch_bus_gnt = 1'b1;
    fbus.wire_instr_ready   = 1'b1;
    fbus.wire_branch_taken  = 1'b0;
    fbus.bus_branch_target  = 16'h0000;

    repeat (3) tick();
    check("rst_ir",    fbus.bus_IR, 16'h0000);
    check("rst_imm",   fbus.bus_IMM, 16'h0000);
    check("rst_pc",    fbus.bus_PC, 16'h0000);
    check("rst_valid", fbus.wire_instr_valid, 1'b0);
    check("rst_req",   fbus.wire_fetch_bus_req, 1'b0);
    check("rst_addr",  fbus.bus_FETCH_ADDRESS, RST_PC);
    rst_n = 1'b1;

    // One-word instruction straight out of reset.
    tick();
    check("w1_req",  fbus.wire_fetch_bus_req, 1'b1);
    check("w1_addr", fbus.bus_FETCH_ADDRESS, 16'h0000);
    wait_valid(c);
    check("w1_latency", c, LAT + 1);
    check("w1_ir",  fbus.bus_IR, 16'h0400);
    check("w1_imm", fbus.bus_IMM, 16'h0000);
    check("w1_pc",  fbus.bus_PC, 16'h0000);
    tick();
    check("w1_next_valid", fbus.wire_instr_valid, 1'b0);
    check("w1_next_addr",  fbus.bus_FETCH_ADDRESS, 16'h0001);

    // Two-word LOADN, then held for 5 cycles with ready low.
    fbus.wire_instr_ready = 1'b0;
    wait_valid(c);
    check("w2_latency", c, 2 * (LAT + 1));
    check("w2_ir",  fbus.bus_IR, 16'hE000);
    check("w2_imm", fbus.bus_IMM, 16'h1234);
    check("w2_pc",  fbus.bus_PC, 16'h0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_stable", {fbus.bus_IR, fbus.bus_IMM, fbus.bus_PC}, 48'hE000_1234_0001);
      check("hold_valid_req", {fbus.wire_instr_valid, fbus.wire_fetch_bus_req}, 2'b10);
    end
    fbus.wire_instr_ready = 1'b1;
    tick();
    check("resume_valid", fbus.wire_instr_valid, 1'b0);
    check("resume_addr",  fbus.bus_FETCH_ADDRESS, 16'h0003);

    // STORE with grant dropped for 3 cycles during the immediate read.
    wait_req_addr(16'h0004);
    tick();
    fbus.wire_fetch_bus_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gnt_loss_state", {fbus.wire_fetch_bus_req, fbus.wire_instr_valid}, 2'b10);
      check("gnt_loss_addr",  fbus.bus_FETCH_ADDRESS, 16'h0004);
    end
    fbus.wire_fetch_bus_gnt = 1'b1;
    wait_valid(c);
    check("store_ir",  fbus.bus_IR, 16'hC400);
    check("store_imm", fbus.bus_IMM, 16'hABCD);
    check("store_pc",  fbus.bus_PC, 16'h0003);
    tick();
    check("store_single_valid", fbus.wire_instr_valid, 1'b0);
    check("store_next_addr",    fbus.bus_FETCH_ADDRESS, 16'h0005);

    // Branch while waiting on the word at 5.
    tick();
    fbus.wire_branch_taken = 1'b1;
    fbus.bus_branch_target = 16'h0100;
    tick();
    fbus.wire_branch_taken = 1'b0;
    fbus.wire_instr_ready  = 1'b0;
    check("br_wait_valid", fbus.wire_instr_valid, 1'b0);
    check("br_wait_addr",  fbus.bus_FETCH_ADDRESS, 16'h0100);
    wait_valid(c);
    check("br_ir",  fbus.bus_IR, 16'h0800);
    check("br_imm", fbus.bus_IMM, 16'h5555);
    check("br_pc",  fbus.bus_PC, 16'h0100);

    // Branch and ready together in HOLD: branch wins.
    fbus.wire_instr_ready  = 1'b1;
    fbus.wire_branch_taken = 1'b1;
    tick();
    fbus.wire_branch_taken = 1'b0;
    check("br_hold_valid", fbus.wire_instr_valid, 1'b0);
    check("br_hold_addr",  fbus.bus_FETCH_ADDRESS, 16'h0100);
    check("br_hold_req",   fbus.wire_fetch_bus_req, 1'b1);
    wait_valid(c);

    // LOAD at 16'hFFFF: immediate wraps to address 0.
    fbus.wire_branch_taken = 1'b1;
    fbus.bus_branch_target = 16'hFFFF;
    tick();
    fbus.wire_branch_taken = 1'b0;
    wait_valid(c);
    check("wrap_ir",  fbus.bus_IR, 16'hC000);
    check("wrap_imm", fbus.bus_IMM, 16'h0400);
    check("wrap_pc",  fbus.bus_PC, 16'hFFFF);
    tick();
    check("wrap_next_addr", fbus.bus_FETCH_ADDRESS, 16'h0001);

    // Randomized traffic; the model process checks every meaningful cycle.
    for (int i = 0; i < 3000; i++) begin
      tick();
      fbus.wire_fetch_bus_gnt = ($urandom_range(0, 3) != 0);
      fbus.wire_instr_ready   = ($urandom_range(0, 2) != 0);
      fbus.wire_branch_taken  = ($urandom_range(0, 39) == 0);
      fbus.bus_branch_target  = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1))
                                                             : 16'($urandom);
    end
    tick();
    fbus.wire_branch_taken  = 1'b0;
    fbus.wire_fetch_bus_gnt = 1'b1;
    fbus.wire_instr_ready   = 1'b1;
    repeat (10) tick();
    check("accepted_enough", (accepted >= 100), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
